// File: rtl/fdiv_issue_queue.sv
// Issue queue for the FDiv/FSqrt unit: holds dispatched ops until their sources
// are ready, issues the oldest eligible op when the single-op unit is idle.
module fdiv_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int PREG_W = 7,
    parameter int ROB_W  = 7,
    parameter int WK_N   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enq_valid,
    output logic                           enq_ready,
    input  logic                           enq_div,
    input  logic [2:0]                     enq_rm,
    input  logic [PREG_W-1:0]              enq_rs1_preg,
    input  logic [PREG_W-1:0]              enq_rs2_preg,
    input  logic                           enq_rs1_rdy,
    input  logic                           enq_rs2_rdy,
    input  logic [PREG_W-1:0]              enq_rd,
    input  logic [ROB_W-1:0]               enq_rob_idx,
    input  logic [WK_N-1:0]                wk_valid,
    input  logic [WK_N-1:0][PREG_W-1:0]    wk_preg,
    output logic                           issue_en,
    output logic                           issue_div,
    output logic [2:0]                     issue_rm,
    output logic [PREG_W-1:0]              issue_rs1_preg,
    output logic [PREG_W-1:0]              issue_rs2_preg,
    output logic [PREG_W-1:0]              issue_rd,
    output logic [ROB_W-1:0]               issue_rob_idx,
    input  logic                           fu_done,
    input  logic                           redirect,
    input  logic [ROB_W-1:0]               redirect_idx
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic              div;
        logic [2:0]        rm;
        logic [PREG_W-1:0] rs1;
        logic [PREG_W-1:0] rs2;
        logic [PREG_W-1:0] rd;
        logic [ROB_W-1:0]  rob;
    } op_t;

    // The MSB of a ROB index is the wrap bit; a differing wrap bit inverts the order.
    function automatic logic is_older(input logic [ROB_W-1:0] a, input logic [ROB_W-1:0] b);
        if (a[ROB_W-1] == b[ROB_W-1]) return a[ROB_W-2:0] < b[ROB_W-2:0];
        else                          return a[ROB_W-2:0] > b[ROB_W-2:0];
    endfunction

    function automatic logic woken(input logic [PREG_W-1:0] p,
                                   input logic [WK_N-1:0] v,
                                   input logic [WK_N-1:0][PREG_W-1:0] pr);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < WK_N; k++) hit = hit | (v[k] && pr[k] == p);
        return hit;
    endfunction

    logic [DEPTH-1:0] valid_q, valid_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    logic [DEPTH-1:0] elig, flush, op_we;
    op_t              op_q [DEPTH];
    op_t              enq_op, iss_op_q;
    logic [CNT_W-1:0] count_q, count_d, n_flush;
    logic             busy_q, busy_d, issue_en_q, flush_infl;
    logic [ROB_W-1:0] infl_q, infl_d;
    logic [IDX_W-1:0] sel_idx, free_idx;
    logic             sel_found, free_found, do_sel, do_enq;

    assign enq_ready = count_q < CNT_W'(DEPTH);
    assign enq_op    = '{div: enq_div, rm: enq_rm, rs1: enq_rs1_preg, rs2: enq_rs2_preg,
                         rd: enq_rd, rob: enq_rob_idx};

    // NOTE: every variable gets a default at the top of always_comb, otherwise a latch is inferred.
    always_comb begin
        elig       = valid_q & rdy1_q & rdy2_q;
        sel_found  = 1'b0;
        sel_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        n_flush    = '0;
        flush      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (elig[i] && (!sel_found || is_older(op_q[i].rob, op_q[sel_idx].rob))) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            flush[i] = redirect && valid_q[i] && !is_older(op_q[i].rob, redirect_idx);
            n_flush  = n_flush + CNT_W'(flush[i]);
        end
        do_sel = sel_found && !busy_q && !redirect;
        do_enq = enq_valid && enq_ready && !redirect && free_found;

        for (int i = 0; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i];
            rdy1_d[i]  = rdy1_q[i] | woken(op_q[i].rs1, wk_valid, wk_preg);
            rdy2_d[i]  = rdy2_q[i] | woken(op_q[i].rs2, wk_valid, wk_preg);
            op_we[i]   = 1'b0;
            if ((do_sel && sel_idx == IDX_W'(i)) || flush[i]) valid_d[i] = 1'b0;
            if (do_enq && free_idx == IDX_W'(i)) begin
                valid_d[i] = 1'b1;
                rdy1_d[i]  = enq_rs1_rdy | woken(enq_rs1_preg, wk_valid, wk_preg);
                rdy2_d[i]  = enq_rs2_rdy | woken(enq_rs2_preg, wk_valid, wk_preg);
                op_we[i]   = 1'b1;
            end
        end

        count_d    = count_q + CNT_W'(do_enq) - CNT_W'(do_sel) - n_flush;
        flush_infl = redirect && busy_q && !is_older(infl_q, redirect_idx);
        // The unit drops a flushed op silently, so done and flush may both clear busy.
        busy_d     = do_sel || (busy_q && !fu_done && !flush_infl);
        infl_d     = do_sel ? op_q[sel_idx].rob : infl_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= '0;
            rdy1_q     <= '0;
            rdy2_q     <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            infl_q     <= '0;
            issue_en_q <= 1'b0;
            iss_op_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            rdy1_q     <= rdy1_d;
            rdy2_q     <= rdy2_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            infl_q     <= infl_d;
            issue_en_q <= do_sel;
            if (do_sel) iss_op_q <= op_q[sel_idx];
        end
    end

    // NOTE: payload storage has no reset; its contents are only used while valid_q is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (op_we[i]) op_q[i] <= enq_op;
        end
    end

    assign issue_en       = issue_en_q;
    assign issue_div      = iss_op_q.div;
    assign issue_rm       = iss_op_q.rm;
    assign issue_rs1_preg = iss_op_q.rs1;
    assign issue_rs2_preg = iss_op_q.rs2;
    assign issue_rd       = iss_op_q.rd;
    assign issue_rob_idx  = iss_op_q.rob;
endmodule

// File: doc/fdiv_issue_queue.md
FDIV_ISSUE_QUEUE -- requirements
Module: fdiv_issue_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of queue entries; power of two, at least 2.
REQ-002 Parameter PREG_W, default 7: physical register index width.
REQ-003 Parameter ROB_W, default 7: ROB index width; MSB is the wrap (direction) bit.
REQ-004 Parameter WK_N, default 4: number of wakeup broadcast ports.
REQ-005 One clock; reset is asynchronous and active-high (ports named clk and rst, as elsewhere in the codebase).
REQ-006 clk  in  1  clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 enq_valid  in  1  dispatch offers one fdiv/fsqrt op.
REQ-009 enq_ready  out  1  queue can accept; equals (count < DEPTH).
REQ-010 enq_div  in  1  1 = divide, 0 = square root.
REQ-011 enq_rm  in  3  rounding mode; 3'b111 = dynamic.
REQ-012 enq_rs1_preg, enq_rs2_preg  in  PREG_W each  source registers.
REQ-013 enq_rs1_rdy, enq_rs2_rdy  in  1 each  source already available at dispatch.
REQ-014 enq_rd  in  PREG_W  destination register.
REQ-015 enq_rob_idx  in  ROB_W  ROB index.
REQ-016 wk_valid  in  WK_N  wakeup valid, one bit per port.
REQ-017 wk_preg  in  WK_N x PREG_W  woken register, one per port.
REQ-018 issue_en  out  1  one-cycle issue pulse to the FDiv unit.
REQ-019 issue_div, issue_rm, issue_rs1_preg, issue_rs2_preg, issue_rd, issue_rob_idx  out  as the enqueue fields  issued op; valid only while issue_en=1.
REQ-020 fu_done  in  1  FDiv unit finished the in-flight op.
REQ-021 redirect  in  1  backend flush request.
REQ-022 redirect_idx  in  ROB_W  flush point.

Function
REQ-023 Age rule: a is older than b iff (a[MSB]==b[MSB] ? a[MSB-1:0] < b[MSB-1:0] : a[MSB-1:0] > b[MSB-1:0]).
REQ-024 Each entry holds: valid, the enqueue fields, rdy1, rdy2.
REQ-025 Enqueue: when enq_valid & enq_ready & ~redirect, write the op into any free entry at the clock edge; otherwise nothing is written.
REQ-026 Wakeup: a valid entry's rdyN is set when any wk_valid[i] is 1 with wk_preg[i] equal to its rsN_preg; this also applies to an op being enqueued in the same cycle, so it enters with the bit already set.
REQ-027 Eligible entry: valid, rdy1=1, rdy2=1, using registered ready bits only; a wakeup in cycle T makes the entry eligible in T+1.
REQ-028 Select: in cycle T, when busy=0, redirect=0 and at least one entry is eligible, choose the oldest eligible entry by REQ-023.
REQ-029 On selection at T: the entry is freed at the edge, busy is set, and the op's rob_idx is stored as inflight_idx.
REQ-030 issue_* outputs are registered: issue_en=1 for exactly cycle T+1, carrying the selected op's fields.
REQ-031 Minimum latency: enqueue with both sources ready at T leads to issue_en=1 at T+2.
REQ-032 busy clears at the edge ending the cycle in which fu_done=1; the earliest next selection is the following cycle.
REQ-033 At most one op is in flight; no selection occurs while busy=1.
REQ-034 Redirect in cycle T: every valid entry whose rob_idx is not older than redirect_idx is invalidated at the edge.
REQ-035 Redirect in cycle T: if busy=1 and inflight_idx is not older than redirect_idx, busy clears at the edge, because the unit drops that op without asserting fu_done.
REQ-036 Redirect in cycle T: no enqueue and no selection occur in T.
REQ-037 If fu_done and a redirect that flushes the in-flight op occur in the same cycle, busy clears exactly once; no error is raised.
REQ-038 count is a registered count of valid entries, width clog2(DEPTH)+1: +1 on enqueue, -1 on selection, minus the number of entries flushed by redirect.
REQ-039 Full queue: enq_ready=0 and enq_valid is ignored; a selection in the same cycle does not allow a same-cycle enqueue.
REQ-040 Empty queue: no selection and no issue_en.

Reset
REQ-041 While rst=1, asynchronously: all entry valid bits=0, count=0, busy=0, issue_en=0, and all issue_* fields=0; consequently enq_ready=1.
REQ-042 Reset mid-operation discards all entries and the in-flight tracking; the first enqueue after rst falls is handled as from the empty state.

Verification
REQ-043 Enqueue div rd=5, rob=3, both sources ready at T -> issue_en=1 at T+2, issue_rd=5, issue_rob_idx=3, count=0.
REQ-044 Enqueue rs1=9 not ready; wk_valid[2]=1 with wk_preg[2]=9 at T -> issue_en=1 at T+2 (select at T+1).
REQ-045 Enqueue ops rob=10, 4, 7, all ready, then fu_done after each -> issue order 4, 7, 10.
REQ-046 Fill 4 entries -> enq_ready=0, a 5th enq_valid is dropped, count stays 4.
REQ-047 Entries rob=2 and rob=6, with rob=1 in flight; redirect, redirect_idx=5 -> rob=6 is flushed, rob=2 is kept, busy stays 1, count=1.
REQ-048 In-flight rob=8; redirect, redirect_idx=8 -> busy=0 next cycle, and a pending eligible older op issues without fu_done.
